// File: rtl/pipe_reg_rv_if.sv
// pipe_reg_rv_if: handshake bundle for one pipeline stage boundary.
//   in_valid / in_ready / in_data    : upstream side (producer -> stage)
//   out_valid / out_ready / out_data : downstream side (stage -> consumer)
//   occupancy                        : number of entries held by the stage (0..2)
// Modports:
//   master : the environment around the stage (drives payload in, ready out)
//   slave  : the stage itself
interface pipe_reg_rv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_reg_rv.sv
// pipe_reg_rv: pipeline stage register with valid/ready handshake,
// synchronous flush and an optional skid entry.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-low reset
//   flush : synchronous clear of all held entries
//   bus   : pipe_reg_rv_if.slave (in_* upstream, out_* downstream, occupancy)
// Parameters:
//   WIDTH      : payload width
//   SKID       : 1 = in_ready independent of out_ready, one extra skid entry;
//                0 = in_ready passes out_ready through, single entry
//   RESET_DATA : value loaded into the data registers on reset and flush
module pipe_reg_rv #(
  parameter int               WIDTH      = 32,
  parameter bit               SKID       = 1'b1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  pipe_reg_rv_if.slave bus
);

  // Main (head) register M; always the entry presented downstream.
  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;

  logic w_accept;
  logic w_drain;

  assign w_drain  = r_m_valid & bus.out_ready;
  assign w_accept = bus.in_valid & bus.in_ready;

  assign bus.out_valid = r_m_valid;
  assign bus.out_data  = r_m_data;

  generate
    if (SKID) begin : g_skid
      // Skid register S: absorbs the one entry that arrives while M is
      // stalled, which lets in_ready be decided without looking at out_ready.
      logic             r_s_valid;
      logic [WIDTH-1:0] r_s_data;

      assign bus.in_ready  = reset & ~r_s_valid & ~flush;
      assign bus.occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};

      always_ff @(posedge clk) begin
        if (!reset || flush) begin
          r_m_valid <= 1'b0;
          r_m_data  <= RESET_DATA;
          r_s_valid <= 1'b0;
          r_s_data  <= RESET_DATA;
        end else if (w_drain) begin
          if (r_s_valid) begin
            // S is older than anything upstream; promote it. in_ready is 0
            // this cycle, so no accept competes for M.
            r_m_data  <= r_s_data;
            r_s_valid <= 1'b0;
          end else if (w_accept) begin
            r_m_data <= bus.in_data;
          end else begin
            r_m_valid <= 1'b0;
          end
        end else if (w_accept) begin
          if (!r_m_valid) begin
            r_m_valid <= 1'b1;
            r_m_data  <= bus.in_data;
          end else begin
            // M is stalled: park the new entry in S.
            r_s_valid <= 1'b1;
            r_s_data  <= bus.in_data;
          end
        end
      end
    end else begin : g_noskid
      // Single entry: space exists if M is empty or leaving this cycle.
      assign bus.in_ready  = reset & ~flush & (~r_m_valid | bus.out_ready);
      assign bus.occupancy = {1'b0, r_m_valid};

      always_ff @(posedge clk) begin
        if (!reset || flush) begin
          r_m_valid <= 1'b0;
          r_m_data  <= RESET_DATA;
        end else if (w_accept) begin
          r_m_valid <= 1'b1;
          r_m_data  <= bus.in_data;
        end else if (w_drain) begin
          r_m_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule
